// File: rtl/perf_run_controller.sv
// Benchmark run sequencer: holds the CPU in reset, times one run, and keeps the
// last/best successful cycle counts for the performance overlay.
module perf_run_controller #(
    parameter logic [15:0] FINAL_PC         = 16'hFFFF,
    parameter logic [31:0] TIMEOUT_CYCLES   = 32'd500_000_000,
    parameter int unsigned CPU_RESET_CYCLES = 16,
    parameter int unsigned TICKS_PER_HUND   = 500_000
) (
    input  logic        CLK_50,
    input  logic        resetN,
    input  logic        start_pulse,
    input  logic        abort_pulse,
    input  logic [15:0] pc,
    output logic        cpu_resetN,
    output logic        counting,
    output logic [31:0] cycle_count,
    output logic [12:0] hund_count,
    output logic [31:0] last_cycles,
    output logic [31:0] best_cycles,
    output logic        best_valid,
    output logic [1:0]  run_status,
    output logic [1:0]  state
);

    localparam int unsigned RW = (CPU_RESET_CYCLES > 1) ? $clog2(CPU_RESET_CYCLES) : 1;
    localparam int unsigned PW = (TICKS_PER_HUND > 1) ? $clog2(TICKS_PER_HUND) : 1;
    localparam logic [RW-1:0] RST_LAST  = RW'(CPU_RESET_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICKS_PER_HUND - 1);
    localparam logic [12:0]   HUND_MAX  = 13'h1FFF;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RESET_CPU = 2'd1,
        S_RUN       = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [1:0] ST_FINISHED = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;
    localparam logic [1:0] ST_ABORTED  = 2'd3;

    state_t      state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [31:0] cycle_q, cycle_d;
    logic [12:0] hund_q, hund_d;
    logic [31:0] last_q, last_d;
    logic [31:0] best_q, best_d;
    logic        best_valid_q, best_valid_d;
    logic [1:0]  status_q, status_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;
    logic        counting_q, counting_d;

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        presc_d      = presc_q;
        cycle_d      = cycle_q;
        hund_d       = hund_q;
        last_d       = last_q;
        best_d       = best_q;
        best_valid_d = best_valid_q;
        status_d     = status_q;
        cpu_rst_n_d  = cpu_rst_n_q;
        counting_d   = counting_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    state_d   = S_RESET_CPU;
                    rst_cnt_d = '0;
                    presc_d   = '0;
                    cycle_d   = '0;
                    hund_d    = '0;
                end
            end
            S_RESET_CPU: begin
                if (abort_pulse) begin
                    state_d  = S_IDLE;
                    status_d = ST_ABORTED;
                end else if (rst_cnt_q == RST_LAST) begin
                    state_d     = S_RUN;
                    cpu_rst_n_d = 1'b1;
                    counting_d  = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // Exit cycles are not counted, so the display freezes on the last counted value.
                if (pc == FINAL_PC) begin
                    state_d      = S_DONE;
                    counting_d   = 1'b0;
                    status_d     = ST_FINISHED;
                    last_d       = cycle_q;
                    best_valid_d = 1'b1;
                    if (!best_valid_q || (cycle_q < best_q)) best_d = cycle_q;
                end else if (abort_pulse) begin
                    state_d    = S_DONE;
                    counting_d = 1'b0;
                    status_d   = ST_ABORTED;
                end else if (cycle_q == TIMEOUT_CYCLES) begin
                    state_d    = S_DONE;
                    counting_d = 1'b0;
                    status_d   = ST_TIMEOUT;
                end else begin
                    cycle_d = cycle_q + 32'd1;
                    if (presc_q == PRESC_TOP) begin
                        presc_d = '0;
                        if (hund_q != HUND_MAX) hund_d = hund_q + 13'd1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (start_pulse) begin
                    state_d     = S_RESET_CPU;
                    cpu_rst_n_d = 1'b0;
                    rst_cnt_d   = '0;
                    presc_d     = '0;
                    cycle_d     = '0;
                    hund_d      = '0;
                end else if (abort_pulse) begin
                    state_d     = S_IDLE;
                    cpu_rst_n_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            presc_q      <= '0;
            cycle_q      <= '0;
            hund_q       <= '0;
            last_q       <= '0;
            best_q       <= '0;
            best_valid_q <= 1'b0;
            status_q     <= '0;
            cpu_rst_n_q  <= 1'b0;
            counting_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            presc_q      <= presc_d;
            cycle_q      <= cycle_d;
            hund_q       <= hund_d;
            last_q       <= last_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            status_q     <= status_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            counting_q   <= counting_d;
        end
    end

    assign cpu_resetN  = cpu_rst_n_q;
    assign counting    = counting_q;
    assign cycle_count = cycle_q;
    assign hund_count  = hund_q;
    assign last_cycles = last_q;
    assign best_cycles = best_q;
    assign best_valid  = best_valid_q;
    assign run_status  = status_q;
    assign state       = state_q;

endmodule

// File: doc/perf_run_controller.md
Name: perf_run_controller

Overview:
Sequences benchmark runs of the CPU for the on-screen performance display. Holds the CPU in reset, releases it on a start request, and gates the clock-cycle and hundredths-of-second counters. Stops the counters on reaching the final PC, on a timeout, or on an abort. Latches the last and best successful cycle counts for the VGA number overlays.

Parameters:
FINAL_PC, 16'hFFFF, PC value that marks benchmark completion
TIMEOUT_CYCLES, 32'd500_000_000, max counted cycles per run (10 s @ 50 MHz); must be >= 1
CPU_RESET_CYCLES, 16, cycles the CPU reset is held low before a run
TICKS_PER_HUND, 500_000, CLK_50 cycles per hundredth of a second

Ports:
CLK_50  in  1  system clock, 50 MHz
resetN  in  1  asynchronous reset, active-low
start_pulse  in  1  single-cycle run request (already debounced)
abort_pulse  in  1  single-cycle abort request
pc  in  16  current CPU program counter
cpu_resetN  out  1  reset to CPU core, active-low
counting  out  1  high while a run is being timed
cycle_count  out  32  live cycle count of current/last run
hund_count  out  13  live hundredths of a second, saturates at 8191
last_cycles  out  32  cycle count of most recent successful run
best_cycles  out  32  minimum cycle count over successful runs
best_valid  out  1  best_cycles holds a real result
run_status  out  2  0 none, 1 finished, 2 timeout, 3 aborted
state  out  2  0 IDLE, 1 RESET_CPU, 2 RUN, 3 DONE

Behaviour:
- Reset (async, resetN low): state IDLE, cpu_resetN=0, counting=0, all counts 0, prescaler 0, best_valid=0, run_status=0. Reset mid-run discards everything, including best.
- All registered; outputs change on posedge CLK_50 only.
- IDLE: cpu_resetN=0. start_pulse -> RESET_CPU; same edge clears cycle_count, hund_count, prescaler, rst_cnt.
- RESET_CPU: cpu_resetN=0 for exactly CPU_RESET_CYCLES cycles (rst_cnt 0..CPU_RESET_CYCLES-1), then RUN. abort_pulse -> IDLE, run_status=3. start_pulse ignored.
- RUN: cpu_resetN=1, counting=1.
  - Each cycle: cycle_count+1.
  - Prescaler +1; when prescaler==TICKS_PER_HUND-1 it wraps to 0 and hund_count increments, saturating at 8191.
  - First RUN cycle is counted as cycle 1.
- RUN exit checks each cycle; priority: final PC > abort > timeout:
  - pc==FINAL_PC: -> DONE, run_status=1. The detection cycle is not counted, so cycle_count freezes. last_cycles<=cycle_count. best_cycles<=cycle_count if !best_valid or cycle_count<best_cycles (ties keep old value); best_valid=1.
  - abort_pulse: -> DONE, run_status=3; last/best unchanged.
  - cycle_count==TIMEOUT_CYCLES: -> DONE, run_status=2; last/best unchanged. cycle_count never exceeds TIMEOUT_CYCLES, so it cannot wrap.
- DONE: cpu_resetN stays 1 (CPU parks at final PC); counting=0; counts frozen for display.
  - start_pulse -> RESET_CPU, new run (clears live counts, keeps last/best/status until next exit).
  - abort_pulse -> IDLE (status kept).
  - start and abort together in DONE: start wins.
- start_pulse in RUN or RESET_CPU is ignored. pc is ignored outside RUN.
- run_status=0 only until the first run ends.

Test Plan:
- Reset then start_pulse with CPU_RESET_CYCLES=4 -> cpu_resetN low 4 more cycles, RUN entered, counting=1; pc=FINAL_PC after 100 RUN cycles -> cycle_count=last_cycles=best_cycles=100, run_status=1, best_valid=1.
- Second run finishing at 150 cycles, third at 80 -> last_cycles=150 then 80; best_cycles=100 then 80; tie at 80 keeps 80.
- TICKS_PER_HUND=10, run of 95 cycles -> hund_count=9; force long run -> hund_count stops at 8191 while cycle_count keeps rising.
- TIMEOUT_CYCLES=50, pc never final -> DONE with cycle_count=50, run_status=2, last/best unchanged.
- pc==FINAL_PC and abort_pulse on same RUN cycle -> run_status=1; abort during RESET_CPU -> IDLE, status=3, cpu_resetN=0.
- resetN pulsed low mid-RUN -> immediately IDLE, cpu_resetN=0, all counts 0, best_valid=0.
